// File: rtl/cmp_pkg.sv
// Shared types for the iterative comparator: compare modes, FSM states and the mode decoder.
package cmp_pkg;

   typedef enum logic [2:0] {
      MODE_EQ    = 3'd0,
      MODE_NE    = 3'd1,
      MODE_LT    = 3'd2,
      MODE_LE    = 3'd3,
      MODE_GT    = 3'd4,
      MODE_GE    = 3'd5,
      MODE_RSVD6 = 3'd6,
      MODE_RSVD7 = 3'd7
   } cmp_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   // Reserved modes always report false.
   function automatic logic mode_result(input cmp_mode_t m, input logic eq, input logic lt);
      logic r;
      r = 1'b0;
      case (m)
         MODE_EQ: r = eq;
         MODE_NE: r = !eq;
         MODE_LT: r = lt;
         MODE_LE: r = lt || eq;
         MODE_GT: r = !lt && !eq;
         MODE_GE: r = !lt;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/iter_comparator_if.sv
// Operand/result handshake bundle for iter_comparator; signed_in exists only with ITER_CMP_SIGNED_EN.
interface iter_comparator_if
   import cmp_pkg::*;
#(
   parameter int NBITS = 16,
   parameter int CHUNK = 4
);
   localparam int NCHUNK = NBITS / CHUNK;
   localparam int CW     = $clog2(NCHUNK + 1);

   logic [NBITS-1:0] a_in;
   logic [NBITS-1:0] b_in;
   cmp_mode_t        mode_in;
   logic             in_valid;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic             out;
   logic [CW-1:0]    cmp_cnt;
`ifdef ITER_CMP_SIGNED_EN
   logic             signed_in;
`endif

   modport master (
      output a_in, b_in, mode_in, in_valid, out_ready,
`ifdef ITER_CMP_SIGNED_EN
      output signed_in,
`endif
      input  in_ready, out_valid, out, cmp_cnt
   );

   modport slave (
      input  a_in, b_in, mode_in, in_valid, out_ready,
`ifdef ITER_CMP_SIGNED_EN
      input  signed_in,
`endif
      output in_ready, out_valid, out, cmp_cnt
   );

endinterface

// File: rtl/iter_comparator_chunk_cmp.sv
// Combinational equality / unsigned less-than for one operand slice.
module chunk_cmp #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq,
   output logic         lt
);

   assign eq = (a == b);
   assign lt = (a < b);

endmodule

// File: rtl/iter_comparator.sv
// Iterative magnitude comparator: one CHUNK slice per cycle, MSB first, early exit on first difference.
// Optional signed compare enabled by defining ITER_CMP_SIGNED_EN.
module iter_comparator
   import cmp_pkg::*;
#(
   parameter int NBITS = 16,
   parameter int CHUNK = 4
) (
   input logic              clk,
   input logic              reset_n,
   iter_comparator_if.slave bus
);

   localparam int NCHUNK = NBITS / CHUNK;
   localparam int CW     = $clog2(NCHUNK + 1);

   generate
      if (CHUNK < 1 || (NBITS % CHUNK) != 0) begin : g_bad_params
         $error("iter_comparator: NBITS must be a positive multiple of CHUNK");
      end
   endgenerate

   cmp_state_t       state;
   logic [NBITS-1:0] a_sh;
   logic [NBITS-1:0] b_sh;
   cmp_mode_t        mode_r;
   logic [CW-1:0]    cnt;
   logic             res;
   logic             sgn_r;
   logic [CHUNK-1:0] ca;
   logic [CHUNK-1:0] cb;
   logic             ceq;
   logic             clt;
   logic [CW-1:0]    cnt_inc;
   logic             last;

   // Operands are shifted left each cycle so the slice under test is always the top CHUNK bits;
   // flipping the sign bits of the first slice turns two's complement order into unsigned order.
   always_comb begin
      ca = a_sh[NBITS-1 -: CHUNK];
      cb = b_sh[NBITS-1 -: CHUNK];
      if (sgn_r && cnt == '0) begin
         ca[CHUNK-1] = ~ca[CHUNK-1];
         cb[CHUNK-1] = ~cb[CHUNK-1];
      end
   end

   chunk_cmp #(.W(CHUNK)) u_chunk (
      .a  (ca),
      .b  (cb),
      .eq (ceq),
      .lt (clt)
   );

   assign cnt_inc = cnt + CW'(1);
   assign last    = (cnt_inc == CW'(NCHUNK));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         mode_r <= MODE_EQ;
         cnt    <= '0;
         res    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh   <= bus.a_in;
                  b_sh   <= bus.b_in;
                  mode_r <= bus.mode_in;
                  cnt    <= '0;
                  state  <= CMP;
               end
            end
            CMP: begin
               cnt  <= cnt_inc;
               a_sh <= a_sh << CHUNK;
               b_sh <= b_sh << CHUNK;
               if (!ceq || last) begin
                  res   <= mode_result(mode_r, ceq, clt);
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ITER_CMP_SIGNED_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sgn_r <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         sgn_r <= bus.signed_in;
      end
   end
`else
   assign sgn_r = 1'b0;
`endif

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out       = res;
   assign bus.cmp_cnt   = cnt;

endmodule

// File: tb/tb_iter_comparator.sv
// Randomized self-checking bench for iter_comparator (NBITS=16, CHUNK=4) against a whole-value reference model.
module tb_iter_comparator;
   import cmp_pkg::*;

   localparam int NB     = 16;
   localparam int CK     = 4;
   localparam int NCHUNK = NB / CK;

   logic clk;
   logic reset_n;
   int   total;
   int   bad;

   iter_comparator_if #(.NBITS(NB), .CHUNK(CK)) bus ();

   iter_comparator #(.NBITS(NB), .CHUNK(CK)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: result from whole-value compare; latency is the index of the first differing chunk.
   function automatic void model(input logic [NB-1:0] a, input logic [NB-1:0] b, input int mode,
                                 input logic sgn, output logic res, output int m);
      logic eq;
      logic lt;
      logic [CK-1:0] sa;
      logic [CK-1:0] sb;
      m = NCHUNK;
      for (int i = 0; i < NCHUNK; i++) begin
         sa = a[NB-1-i*CK -: CK];
         sb = b[NB-1-i*CK -: CK];
         if (sa != sb) begin
            m = i + 1;
            break;
         end
      end
      eq = (a == b);
      lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
      case (mode)
         0: res = eq;
         1: res = !eq;
         2: res = lt;
         3: res = lt || eq;
         4: res = !lt && !eq;
         5: res = !lt;
         default: res = 1'b0;
      endcase
   endfunction

   task automatic applyStimulus(input logic [NB-1:0] a, input logic [NB-1:0] b, input int mode,
                                input logic sgn, input int hold);
      logic expRes;
      int   expM;
      int   lat;
      logic seen;
      logic sgnEff;
      logic holdOut;
      logic [31:0] holdCnt;
`ifdef ITER_CMP_SIGNED_EN
      sgnEff = sgn;
`else
      sgnEff = 1'b0;
`endif
      model(a, b, mode, sgnEff, expRes, expM);
      checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.a_in     = a;
      bus.b_in     = b;
      bus.mode_in  = cmp_mode_t'(mode[2:0]);
`ifdef ITER_CMP_SIGNED_EN
      bus.signed_in = sgn;
`endif
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a_in     = NB'($urandom);
      bus.b_in     = NB'($urandom);
      bus.mode_in  = cmp_mode_t'($urandom_range(0, 7));
`ifdef ITER_CMP_SIGNED_EN
      bus.signed_in = ~sgn;
`endif
      checkOutput("in_ready_busy", 32'(bus.in_ready), 32'd0);
      lat  = 0;
      seen = 1'b0;
      for (int k = 0; k < NCHUNK + 4; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("out_valid_seen", 32'(seen), 32'd1);
      checkOutput("latency", 32'(lat), 32'(expM));
      checkOutput("out", 32'(bus.out), 32'(expRes));
      checkOutput("cmp_cnt", 32'(bus.cmp_cnt), 32'(expM));
      checkOutput("in_ready_done", 32'(bus.in_ready), 32'd0);
      holdOut = bus.out;
      holdCnt = 32'(bus.cmp_cnt);
      // Stall the consumer while offering a fresh request that must be ignored.
      for (int k = 0; k < hold; k++) begin
         bus.in_valid = 1'b1;
         bus.a_in     = NB'($urandom);
         bus.b_in     = NB'($urandom);
         @(posedge clk);
         #1;
         checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("hold_out", 32'(bus.out), 32'(holdOut));
         checkOutput("hold_cnt", 32'(bus.cmp_cnt), holdCnt);
         checkOutput("hold_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput("back_to_idle", 32'(bus.in_ready), 32'd1);
      checkOutput("valid_drop", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic [NB-1:0] ra;
      logic [NB-1:0] rb;
      total         = 0;
      bad           = 0;
      reset_n       = 1'b0;
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.mode_in   = MODE_EQ;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
`ifdef ITER_CMP_SIGNED_EN
      bus.signed_in = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out", 32'(bus.out), 32'd0);
      checkOutput("rst_cmp_cnt", 32'(bus.cmp_cnt), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

      $display("[TB] directed cases");
      applyStimulus(16'h1234, 16'h1234, 0, 1'b0, 0);
      applyStimulus(16'h9000, 16'h1000, 2, 1'b0, 0);
      applyStimulus(16'h9000, 16'h1000, 2, 1'b1, 0);
      applyStimulus(16'h1235, 16'h1234, 4, 1'b0, 0);
      applyStimulus(16'h1235, 16'h1234, 3, 1'b0, 0);
      applyStimulus(16'hABCD, 16'h0123, 7, 1'b0, 0);
      applyStimulus(16'h5555, 16'h5555, 6, 1'b0, 1);
      applyStimulus(16'h4321, 16'h4300, 5, 1'b0, 3);

      $display("[TB] reset during compare");
      bus.a_in     = 16'h7777;
      bus.b_in     = 16'h7777;
      bus.mode_in  = MODE_EQ;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("midrst_cmp_cnt", 32'(bus.cmp_cnt), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(16'h0F00, 16'h0E00, 4, 1'b0, 0);

      $display("[TB] random cases");
      for (int n = 0; n < 150; n++) begin
         ra = NB'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (NB'(1) << $urandom_range(0, NB - 1));
            2:       rb = ra ^ NB'($urandom_range(0, 255));
            default: rb = NB'($urandom);
         endcase
         applyStimulus(ra, rb, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/iter_comparator.md
ITER_COMPARATOR -- requirements
Module: iter_comparator

Interface
REQ-001 Parameter NBITS, default 16, operand width in bits.
REQ-002 Parameter CHUNK, default 4, bits compared per cycle; NBITS SHALL be a multiple of CHUNK, else elaboration error.
REQ-003 Derived NCHUNK = NBITS/CHUNK; CW = $clog2(NCHUNK+1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 a_in  input  NBITS  first operand.
REQ-007 b_in  input  NBITS  second operand.
REQ-008 mode_in  input  3  compare mode (cmp_mode_t).
REQ-009 in_valid  input  1  operands/mode valid.
REQ-010 in_ready  output  1  block can accept; high only in IDLE.
REQ-011 out_valid  output  1  result valid; high only in DONE.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  1  compare result, 1 = True, 0 = False.
REQ-014 cmp_cnt  output  CW  chunks examined for the current result (1..NCHUNK).

Function
REQ-015 FSM states IDLE, CMP, DONE; IDLE->CMP on in_valid && in_ready; CMP->DONE on first differing chunk or after last chunk; DONE->IDLE on out_ready.
REQ-016 On accept, a_in, b_in, mode_in SHALL be registered; later input changes SHALL NOT affect the result.
REQ-017 CMP SHALL examine one CHUNK slice per cycle, most-significant chunk first.
REQ-018 First unequal chunk SHALL terminate early, latching lt/gt from that chunk; all chunks equal latches eq.
REQ-019 out_valid SHALL rise m cycles after the accept edge, m = chunks examined = cmp_cnt; equal operands give m = NCHUNK.
REQ-020 Modes: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE (a relative to b); 6, 7 reserved -> out = 0 with normal timing.
REQ-021 Comparison SHALL be unsigned unless signed mode per REQ-028 applies.
REQ-022 out and cmp_cnt SHALL be held stable while out_valid && !out_ready.
REQ-023 in_valid outside IDLE SHALL be ignored (no capture, no state change).
REQ-024 CHUNK == NBITS SHALL give single-cycle CMP, cmp_cnt = 1 always.
REQ-025 Back-to-back: DONE->IDLE handoff costs one cycle; next accept earliest the cycle after out_ready handshake.

Reset
REQ-026 reset_n low SHALL force IDLE immediately, regardless of state (including mid-CMP), discarding any operation.
REQ-027 Reset values: in_ready = 1 (after deassertion), out_valid = 0, out = 0, cmp_cnt = 0, chunk index = 0.

Configuration
REQ-028 Macro ITER_CMP_SIGNED_EN defined: port signed_in (input 1) added, captured with operands; when 1, MSB chunk compared with operand sign bits inverted (two's complement order).
REQ-029 Macro absent: signed_in port does not exist; all comparison unsigned.

Structure
REQ-030 Package cmp_pkg SHALL hold cmp_mode_t enum (3-bit) and cmp_state_t enum (IDLE, CMP, DONE).
REQ-031 Sub-module chunk_cmp (parameter W) SHALL be purely combinational, outputs eq and lt for one slice; instantiated once in iter_comparator.

Verification (NBITS=16, CHUNK=4)
REQ-032 a=16'h1234, b=16'h1234, EQ -> out=1, cmp_cnt=4, out_valid 4 cycles after accept.
REQ-033 a=16'h9000, b=16'h1000, LT unsigned -> out=0, cmp_cnt=1; with ITER_CMP_SIGNED_EN and signed_in=1 -> out=1, cmp_cnt=1.
REQ-034 a=16'h1235, b=16'h1234, GT -> out=1, cmp_cnt=4; same with LE -> out=0.
REQ-035 Result ready, out_ready low 3 cycles -> out, cmp_cnt, out_valid stable, in_ready=0, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-036 reset_n pulsed low during CMP (chunk 2) -> immediate IDLE, out_valid=0, cmp_cnt=0; next operation completes correctly.
REQ-037 mode_in=7, any operands -> out=0, normal handshake timing.
